// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, arbiter FSM states and register-slave offsets
// used by the two-requester register master.
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } arb_state_e;

  // Word offsets of the register slave; byte address is offset << 2.
  localparam logic [1:0] REG0 = 2'h0;
  localparam logic [1:0] REG1 = 2'h1;
  localparam logic [1:0] REG2 = 2'h2;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  function automatic logic [1:0] idx2oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: round-robin on ties by default, fixed priority to
// requester 0 when AHBL_ARB_FIXED_PRIORITY_EN is defined.
module rr_arbiter2
  import ahbl_pkg::*;
#(
  parameter logic RESET_LAST_GRANT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       winner
);

`ifdef AHBL_ARB_FIXED_PRIORITY_EN
  always_comb begin
    winner = ~req[0];
    grant  = (req != 2'b00) ? idx2oh(winner) : 2'b00;
  end
`else
  logic last_q, last_d;

  always_comb begin
    unique case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_q;
      default: winner = 1'b0;
    endcase
    grant  = (req != 2'b00) ? idx2oh(winner) : 2'b00;
    last_d = (advance && (req != 2'b00)) ? winner : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= RESET_LAST_GRANT;
    else        last_q <= last_d;
  end
`endif

endmodule

// File: rtl/ahbl_reg_master_arbiter.sv
// Two-requester AHB-Lite master issuing single non-pipelined word transfers.
// Optional AHBL_ARB_FIXED_PRIORITY_EN: fixed priority plus data-phase watchdog.
module ahbl_reg_master_arbiter
  import ahbl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES   = 16,
  parameter logic        RESET_LAST_GRANT = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic        busy
);

  arb_state_e  state_q, state_d;
  bus_req_t    req_q, req_d;
  logic        win_q, win_d;
  logic        first_q, first_d;
  logic [31:0] rdata_q, rdata_d;
  logic        advance, winner, timeout;
  logic [1:0]  grant;

  assign advance = (state_q == ST_IDLE) && (req_valid != 2'b00);

  rr_arbiter2 #(.RESET_LAST_GRANT(RESET_LAST_GRANT)) u_arb (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .req     (req_valid),
    .advance (advance),
    .grant   (grant),
    .winner  (winner)
  );

`ifdef AHBL_ARB_FIXED_PRIORITY_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // The last permitted wait cycle ends the data phase instead of extending it.
  assign timeout = (state_q == ST_DATA) && !HREADY &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = ((state_q == ST_DATA) && !HREADY) ? cnt_q + 1'b1 : '0;
    err_d = err_q;
    if (advance)      err_d = 1'b0;
    else if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  // No watchdog in this build; the parameter stays for a uniform interface.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (advance) state_d = ST_ADDR;
      ST_ADDR: if (HREADY) state_d = ST_DATA;
      ST_DATA: if (HREADY || timeout) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    HTRANS    = HTRANS_IDLE;
    HWRITE    = 1'b0;
    HWDATA    = '0;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    unique case (state_q)
      ST_ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        HWRITE = req_q.write;
        if (first_q) req_ready = idx2oh(win_q);
      end
      ST_DATA: if (req_q.write) HWDATA = req_q.wdata;
      ST_RESP: rsp_valid = idx2oh(win_q);
      default: ;
    endcase
  end

  assign HADDR     = req_q.addr;
  assign HSIZE     = HSIZE_WORD;
  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != ST_IDLE);

  // Request latch and read-data capture
  always_comb begin
    req_d   = req_q;
    win_d   = win_q;
    rdata_d = rdata_q;
    first_d = advance;
    if (advance) begin
      win_d       = winner;
      req_d.write = grant[1] ? req_write[1] : req_write[0];
      req_d.addr  = grant[1] ? req_addr1    : req_addr0;
      req_d.wdata = grant[1] ? req_wdata1   : req_wdata0;
    end
    if ((state_q == ST_DATA) && HREADY && !req_q.write) rdata_d = HRDATA;
    if (timeout) rdata_d = 32'hDEAD_BEEF;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      req_q   <= '0;
      win_q   <= 1'b0;
      first_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      req_q   <= req_d;
      win_q   <= win_d;
      first_q <= first_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
